// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and helpers for the bypassing register file
package regfile_pkg;

  localparam int DEF_WORD_SIZE = 32;
  localparam int DEF_NUM_REGS  = 32;
  localparam int DEF_NUM_RD    = 2;

  // Hard-wired zero register index
  localparam int ZERO_REG = 0;

  // Low bit of field idx in a packed vector of width-bit fields
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending bits and outstanding-op counter
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int CNT_W    = $clog2(NUM_REGS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                rsv_en,
  input  logic [ADDR_W-1:0]   rsv_addr,
  output logic                rsv_ok,
  output logic [NUM_REGS-1:0] pending,
  output logic [CNT_W-1:0]    outstanding
);

  logic wr_in_range;
  logic rsv_in_range;
  logic wr_hit;
  logic wr_pend;
  logic rsv_zero;
  logic rsv_pend;
  logic rsv_set;
  logic inc;
  logic dec;

  assign wr_in_range  = int'(wr_addr) < NUM_REGS;
  assign rsv_in_range = int'(rsv_addr) < NUM_REGS;
  assign rsv_zero     = (rsv_addr == ADDR_W'(ZERO_REG));

  // A write to r0 or past the end of the array never touches state
  assign wr_hit   = we && wr_in_range && (wr_addr != ADDR_W'(ZERO_REG));
  assign wr_pend  = wr_hit && pending[wr_addr];
  assign rsv_pend = rsv_in_range && pending[rsv_addr];

  // Reserve is refused only on WAW (still pending, no retiring write to it)
  // or on an address that does not exist; r0 is always accepted as a no-op
  assign rsv_ok = rsv_en && (rsv_zero ||
                  (rsv_in_range && (!rsv_pend || (we && (wr_addr == rsv_addr)))));

  assign rsv_set = rsv_ok && !rsv_zero;

  // Count only real 0->1 and 1->0 transitions; a retire that is re-reserved
  // in the same cycle leaves the bit at 1 and the count alone
  assign inc = rsv_set && !rsv_pend;
  assign dec = wr_pend && !(rsv_set && (rsv_addr == wr_addr));

  // Pending vector and outstanding counter; reserve wins over a same-cycle write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      outstanding <= '0;
    end else begin
      if (wr_hit) begin
        pending[wr_addr] <= 1'b0;
      end
      if (rsv_set) begin
        pending[rsv_addr] <= 1'b1;
      end
      case ({inc, dec})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  a_count_matches : assert property (@(posedge clk) disable iff (!rst_n)
    outstanding == CNT_W'($countones(pending)));

endmodule

// File: rtl/regfile_bypass_sb.sv
// rtl/regfile_bypass_sb.sv - multi-port register file with write bypass and pending scoreboard
module regfile_bypass_sb
  import regfile_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int ADDR_W    = $clog2(NUM_REGS),
  parameter int NUM_RD    = DEF_NUM_RD,
  parameter int BYPASS    = 1,
  parameter int CNT_W     = $clog2(NUM_REGS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD*WORD_SIZE-1:0] rd_data,
  output logic [NUM_RD-1:0]         rd_busy,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [WORD_SIZE-1:0]      wr_data,
  input  logic                      rsv_en,
  input  logic [ADDR_W-1:0]         rsv_addr,
  output logic                      rsv_ok,
  output logic [CNT_W-1:0]          outstanding
);

  logic [WORD_SIZE-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]  pending;
  logic                 wr_hit;

  assign wr_hit = we && (int'(wr_addr) < NUM_REGS) && (wr_addr != ADDR_W'(ZERO_REG));

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .CNT_W    (CNT_W)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .we          (we),
    .wr_addr     (wr_addr),
    .rsv_en      (rsv_en),
    .rsv_addr    (rsv_addr),
    .rsv_ok      (rsv_ok),
    .pending     (pending),
    .outstanding (outstanding)
  );

  // Data array; r0 is never written so it stays at its reset value of zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
    end else if (wr_hit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0]    addr;
    logic                 valid;
    logic                 byp;
    logic [WORD_SIZE-1:0] data;
    logic                 busy;

    assign addr  = rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];
    assign valid = (addr != ADDR_W'(ZERO_REG)) && (int'(addr) < NUM_REGS);
    assign byp   = (BYPASS != 0) && we && (wr_addr == addr);

    // Operand mux: zero for r0/out-of-range, then in-flight write, then array
    always_comb begin
      data = '0;
      busy = 1'b0;
      if (valid) begin
        data = byp ? wr_data : regs[addr];
        busy = pending[addr] && !byp;
      end
    end

    assign rd_data[slice_lo(i, WORD_SIZE) +: WORD_SIZE] = data;
    assign rd_busy[i] = busy;
  end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// tb/tb_regfile_bypass_sb.sv - directed self-checking bench for regfile_bypass_sb
module tb_regfile_bypass_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  busy_b, busy_n;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        rsv_ok_b, rsv_ok_n;
  logic [5:0]  out_b, out_n;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  regfile_bypass_sb #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(busy_b),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_ok(rsv_ok_b), .outstanding(out_b)
  );

  regfile_bypass_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(busy_n),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_ok(rsv_ok_n), .outstanding(out_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); rd_addr = '0;
    #2;
    for (int r = 0; r < 32; r++) begin
      rd_addr = {5'(31 - r), 5'(r)};
      #1;
      vecs++;
      if (rd_data_b !== 64'h0 || rd_data_n !== 64'h0) begin
        errs++; $display("FAIL reset_data r%0d got %h / %h exp 0", r, rd_data_b, rd_data_n);
      end
      vecs++;
      if (busy_b !== 2'b00 || busy_n !== 2'b00) begin
        errs++; $display("FAIL reset_busy r%0d got %b / %b exp 00", r, busy_b, busy_n);
      end
    end
    vecs++;
    if (out_b !== 6'd0 || out_n !== 6'd0 || rsv_ok_b !== 1'b0) begin
      errs++; $display("FAIL reset_outstanding got %0d / %0d rsv_ok %b exp 0 0 0", out_b, out_n, rsv_ok_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_bypass();
    we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    rd_addr = {5'd0, 5'd5};
    #1;
    vecs++;
    if (rd_data_b[31:0] !== 32'hDEADBEEF) begin
      errs++; $display("FAIL bypass_same_cycle got %h exp deadbeef", rd_data_b[31:0]);
    end
    vecs++;
    if (rd_data_n[31:0] !== 32'h0) begin
      errs++; $display("FAIL nobypass_same_cycle got %h exp 0", rd_data_n[31:0]);
    end
    tick();
    idle();
    rd_addr = {5'd5, 5'd5};
    #1;
    vecs++;
    if (rd_data_b !== {2{32'hDEADBEEF}} || rd_data_n !== {2{32'hDEADBEEF}}) begin
      errs++; $display("FAIL write_next_cycle got %h / %h exp deadbeef x2", rd_data_b, rd_data_n);
    end
  endtask

  task automatic test_zero_reg();
    we = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    rd_addr = {5'd5, 5'd0};
    #1;
    vecs++;
    if (rd_data_b[31:0] !== 32'h0) begin
      errs++; $display("FAIL r0_bypass got %h exp 0", rd_data_b[31:0]);
    end
    tick();
    idle();
    #1;
    vecs++;
    if (rd_data_b[31:0] !== 32'h0 || rd_data_n[31:0] !== 32'h0) begin
      errs++; $display("FAIL r0_read got %h / %h exp 0", rd_data_b[31:0], rd_data_n[31:0]);
    end
    rsv_en = 1'b1; rsv_addr = 5'd0;
    #1;
    vecs++;
    if (rsv_ok_b !== 1'b1) begin
      errs++; $display("FAIL r0_rsv_ok got %b exp 1", rsv_ok_b);
    end
    tick();
    idle();
    #1;
    vecs++;
    if (out_b !== 6'd0 || busy_b[0] !== 1'b0) begin
      errs++; $display("FAIL r0_rsv_state outstanding %0d busy %b exp 0 0", out_b, busy_b[0]);
    end
  endtask

  task automatic test_reserve_retire();
    rsv_en = 1'b1; rsv_addr = 5'd7;
    #1;
    vecs++;
    if (rsv_ok_b !== 1'b1) begin
      errs++; $display("FAIL rsv7_ok got %b exp 1", rsv_ok_b);
    end
    tick();
    idle();
    rd_addr = {5'd5, 5'd7};
    #1;
    vecs++;
    if (busy_b !== 2'b01 || busy_n !== 2'b01 || out_b !== 6'd1) begin
      errs++; $display("FAIL rsv7_busy busy %b / %b outstanding %0d exp 01 01 1", busy_b, busy_n, out_b);
    end
    rsv_en = 1'b1; rsv_addr = 5'd7;
    #1;
    vecs++;
    if (rsv_ok_b !== 1'b0 || rsv_ok_n !== 1'b0) begin
      errs++; $display("FAIL waw_reject got %b / %b exp 0", rsv_ok_b, rsv_ok_n);
    end
    tick();
    idle();
    #1;
    vecs++;
    if (out_b !== 6'd1) begin
      errs++; $display("FAIL waw_no_change outstanding %0d exp 1", out_b);
    end
    we = 1'b1; wr_addr = 5'd7; wr_data = 32'h12;
    #1;
    vecs++;
    if (busy_b[0] !== 1'b0 || busy_n[0] !== 1'b1 || rd_data_b[31:0] !== 32'h12) begin
      errs++; $display("FAIL retire_same_cycle busy %b / %b data %h exp 0 1 12", busy_b[0], busy_n[0], rd_data_b[31:0]);
    end
    tick();
    idle();
    #1;
    vecs++;
    if (busy_b !== 2'b00 || busy_n !== 2'b00 || out_b !== 6'd0 || rd_data_n[31:0] !== 32'h12) begin
      errs++; $display("FAIL retire_after busy %b / %b outstanding %0d data %h exp 00 00 0 12",
                       busy_b, busy_n, out_b, rd_data_n[31:0]);
    end
  endtask

  task automatic test_back_to_back();
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick();
    idle();
    vecs++;
    if (out_b !== 6'd1) begin
      errs++; $display("FAIL rsv9 outstanding %0d exp 1", out_b);
    end
    rsv_en = 1'b1; rsv_addr = 5'd9;
    we = 1'b1; wr_addr = 5'd9; wr_data = 32'hCAFE;
    #1;
    vecs++;
    if (rsv_ok_b !== 1'b1) begin
      errs++; $display("FAIL rsv_write_same_ok got %b exp 1", rsv_ok_b);
    end
    tick();
    idle();
    rd_addr = {5'd0, 5'd9};
    #1;
    vecs++;
    if (out_b !== 6'd1 || busy_b[0] !== 1'b1 || rd_data_b[31:0] !== 32'hCAFE) begin
      errs++; $display("FAIL rsv_write_same outstanding %0d busy %b data %h exp 1 1 cafe",
                       out_b, busy_b[0], rd_data_b[31:0]);
    end
    rsv_en = 1'b1; rsv_addr = 5'd3;
    we = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    #1;
    vecs++;
    if (rsv_ok_b !== 1'b1) begin
      errs++; $display("FAIL rsv3_ok got %b exp 1", rsv_ok_b);
    end
    tick();
    idle();
    rd_addr = {5'd9, 5'd3};
    #1;
    vecs++;
    if (out_b !== 6'd1 || out_n !== 6'd1 || busy_b !== 2'b01 || rd_data_b[63:32] !== 32'h99) begin
      errs++; $display("FAIL rsv_and_retire outstanding %0d busy %b data %h exp 1 01 99",
                       out_b, busy_b, rd_data_b[63:32]);
    end
    we = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    tick();
    idle();
    vecs++;
    if (out_b !== 6'd0 || busy_b !== 2'b00) begin
      errs++; $display("FAIL retire3 outstanding %0d busy %b exp 0 00", out_b, busy_b);
    end
  endtask

  task automatic test_async_reset();
    we = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
    rsv_en = 1'b1; rsv_addr = 5'd1;
    tick();
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd2;
    tick();
    rsv_addr = 5'd3;
    tick();
    idle();
    rd_addr = {5'd2, 5'd1};
    #1;
    vecs++;
    if (out_b !== 6'd3 || busy_b !== 2'b11) begin
      errs++; $display("FAIL pre_reset outstanding %0d busy %b exp 3 11", out_b, busy_b);
    end
    rst_n = 1'b0;
    #1;
    vecs++;
    if (out_b !== 6'd0 || out_n !== 6'd0 || busy_b !== 2'b00 || busy_n !== 2'b00) begin
      errs++; $display("FAIL async_reset outstanding %0d / %0d busy %b / %b exp 0 0 00 00",
                       out_b, out_n, busy_b, busy_n);
    end
    rd_addr = {5'd5, 5'd4};
    #1;
    vecs++;
    if (rd_data_b !== 64'h0 || rd_data_n !== 64'h0) begin
      errs++; $display("FAIL async_reset_data got %h / %h exp 0", rd_data_b, rd_data_n);
    end
    rst_n = 1'b1;
    tick();
    rd_addr = {5'd3, 5'd4};
    #1;
    vecs++;
    if (busy_b !== 2'b00 || out_b !== 6'd0 || rd_data_b !== 64'h0) begin
      errs++; $display("FAIL post_reset busy %b outstanding %0d data %h exp 00 0 0", busy_b, out_b, rd_data_b);
    end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_zero_reg();
    test_reserve_retire();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
